// File: rtl/capture_ram_ctrl.sv
// ---------------------------------------------------------------------------
// capture_ram_ctrl
//
// Circular sample buffer plus capture control for the scope front end.
// A capture runs in this order:
//   1. arm
//   2. PRE fill (trig_pos samples)
//   3. WAIT for a qualified trigger, still writing
//   4. POST fill (DEPTH-1-trig_pos samples)
//   5. DONE, where the buffer can be read out
// Read-out is trigger relative: logical index 0 is always the oldest sample.
//
// Optional feature: define CAPTURE_AUTO_TRIG_EN to force a trigger after
// AUTO_TO valid samples spent in WAIT. When the macro is undefined, auto_trig
// is tied low and WAIT lasts until a real trigger arrives.
//
// Ports:
//   rclk          clock
//   rst           synchronous active-high reset
//   arm           start / restart a capture (single-cycle pulse)
//   trig_pos      pre-trigger sample count, latched on arm
//   smpl_vld      smpl_data valid this cycle
//   smpl_data     NUM_CH samples, channel 0 in the LSBs
//   trig          trigger event, qualified by smpl_vld
//   rd_en         read request (accepted only in DONE)
//   rd_addr       logical read index, 0 = oldest sample
//   rd_data       read data, one cycle after an accepted rd_en
//   rd_vld        single-cycle pulse per accepted read
//   busy          capture in progress (PRE, WAIT, POST)
//   capture_done  capture complete (DONE)
//   trig_addr     physical address of the trigger sample
//   auto_trig     the capture was force-triggered by the timeout
// ---------------------------------------------------------------------------
module capture_ram_ctrl #(
  parameter int DATA_W  = 8,
  parameter int ADDR_W  = 9,
  parameter int NUM_CH  = 1,
  parameter int AUTO_TO = 1024
) (
  input  logic                     rclk,
  input  logic                     rst,
  input  logic                     arm,
  input  logic [ADDR_W-1:0]        trig_pos,
  input  logic                     smpl_vld,
  input  logic [NUM_CH*DATA_W-1:0] smpl_data,
  input  logic                     trig,
  input  logic                     rd_en,
  input  logic [ADDR_W-1:0]        rd_addr,
  output logic [NUM_CH*DATA_W-1:0] rd_data,
  output logic                     rd_vld,
  output logic                     busy,
  output logic                     capture_done,
  output logic [ADDR_W-1:0]        trig_addr,
  output logic                     auto_trig
);

  localparam int DEPTH  = 2**ADDR_W;
  localparam int WORD_W = NUM_CH*DATA_W;

  // Post-trigger count is DEPTH-1-trig_pos, which needs one extra bit of
  // headroom while it is being formed.
  localparam logic [ADDR_W:0] DEPTH_M1 = (ADDR_W+1)'(DEPTH-1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PRE,
    S_WAIT,
    S_POST,
    S_DONE
  } state_t;

  state_t state;

  logic [WORD_W-1:0] ram [DEPTH];

  logic [ADDR_W-1:0] waddr;
  logic [ADDR_W-1:0] trig_pos_q;
  logic [ADDR_W:0]   pre_cnt;
  logic [ADDR_W:0]   post_cnt;

  logic              wr_en;
  logic              rd_accept;
  logic              timeout;
  logic [ADDR_W:0]   pre_cnt_nxt;
  logic [ADDR_W:0]   post_init;
  logic [ADDR_W-1:0] start_addr;
  logic [ADDR_W-1:0] rd_phys;

  // arm pre-empts everything in its cycle, so it blocks both the write
  // and the read that would otherwise happen.
  assign wr_en     = !arm && smpl_vld &&
                     ((state == S_PRE) || (state == S_WAIT) || (state == S_POST));
  assign rd_accept = !arm && rd_en && (state == S_DONE);

  assign pre_cnt_nxt = pre_cnt + 1'b1;
  assign post_init   = DEPTH_M1 - {1'b0, trig_pos_q};

  // The oldest sample sits trig_pos entries before the trigger. Both
  // subtraction and addition wrap naturally at ADDR_W bits (mod DEPTH).
  assign start_addr = trig_addr - trig_pos_q;
  assign rd_phys    = start_addr + rd_addr;

`ifdef CAPTURE_AUTO_TRIG_EN
  localparam int TO_W = $clog2(AUTO_TO + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(AUTO_TO - 1);

  logic [TO_W-1:0] wait_cnt;

  // wait_cnt holds the number of valid samples already taken in WAIT, so
  // the sample arriving when it equals AUTO_TO-1 is the AUTO_TO-th one.
  assign timeout = (wait_cnt == TO_LAST);
`else
  assign timeout   = 1'b0;
  assign auto_trig = 1'b0;
`endif

  // Capture FSM.
  // busy and capture_done are registered together with the state
  // transitions, so they always match the state being entered.
  always_ff @(posedge rclk) begin
    if (rst) begin
      state        <= S_IDLE;
      waddr        <= '0;
      trig_pos_q   <= '0;
      pre_cnt      <= '0;
      post_cnt     <= '0;
      trig_addr    <= '0;
      busy         <= 1'b0;
      capture_done <= 1'b0;
`ifdef CAPTURE_AUTO_TRIG_EN
      auto_trig    <= 1'b0;
      wait_cnt     <= '0;
`endif
    end else if (arm) begin
      trig_pos_q   <= trig_pos;
      waddr        <= '0;
      pre_cnt      <= '0;
      busy         <= 1'b1;
      capture_done <= 1'b0;
      state        <= (trig_pos == '0) ? S_WAIT : S_PRE;
`ifdef CAPTURE_AUTO_TRIG_EN
      auto_trig    <= 1'b0;
      wait_cnt     <= '0;
`endif
    end else begin
      if (wr_en) begin
        waddr <= waddr + 1'b1;
      end

      case (state)
        S_PRE: begin
          if (wr_en) begin
            pre_cnt <= pre_cnt_nxt;
            if (pre_cnt_nxt == {1'b0, trig_pos_q}) begin
              state <= S_WAIT;
`ifdef CAPTURE_AUTO_TRIG_EN
              wait_cnt <= '0;
`endif
            end
          end
        end

        S_WAIT: begin
          if (wr_en) begin
            if (trig || timeout) begin
              // The trigger sample is written at the current waddr, so that
              // (pre-increment) address becomes the trigger reference.
              trig_addr <= waddr;
              post_cnt  <= post_init;
`ifdef CAPTURE_AUTO_TRIG_EN
              auto_trig <= !trig;
`endif
              if (post_init == '0) begin
                state        <= S_DONE;
                busy         <= 1'b0;
                capture_done <= 1'b1;
              end else begin
                state <= S_POST;
              end
            end else begin
`ifdef CAPTURE_AUTO_TRIG_EN
              wait_cnt <= wait_cnt + 1'b1;
`endif
            end
          end
        end

        S_POST: begin
          if (wr_en) begin
            post_cnt <= post_cnt - 1'b1;
            if (post_cnt == (ADDR_W+1)'(1)) begin
              state        <= S_DONE;
              busy         <= 1'b0;
              capture_done <= 1'b1;
            end
          end
        end

        default: begin
        end
      endcase
    end
  end

  // Sample RAM write port. No reset, so it maps onto block RAM.
  // The contents survive rst.
  always_ff @(posedge rclk) begin
    if (wr_en) begin
      ram[waddr] <= smpl_data;
    end
  end

  // Read port with a registered output. Writes never happen in DONE, so a
  // read cannot collide with a write. rd_data keeps its last value when no
  // read is accepted.
  always_ff @(posedge rclk) begin
    if (rst) begin
      rd_data <= '0;
      rd_vld  <= 1'b0;
    end else begin
      rd_vld <= rd_accept;
      if (rd_accept) begin
        rd_data <= ram[rd_phys];
      end
    end
  end

endmodule

// File: tb/tb_capture_ram_ctrl.sv
// ---------------------------------------------------------------------------
// tb_capture_ram_ctrl
//
// Self-checking bench for capture_ram_ctrl with default parameters
// (DEPTH = 512, NUM_CH = 1).
//
// The reference model keeps the whole written sample history in a queue.
// Capture phase, trigger index, completion and read-out contents are all
// derived arithmetically from that history and from the latched trig_pos.
// When CAPTURE_AUTO_TRIG_EN is defined the model also applies the
// auto-trigger timeout.
// ---------------------------------------------------------------------------
module tb_capture_ram_ctrl;

  localparam int DATA_W  = 8;
  localparam int ADDR_W  = 9;
  localparam int NUM_CH  = 1;
  localparam int AUTO_TO = 1024;
  localparam int DEPTH   = 2**ADDR_W;

`ifdef CAPTURE_AUTO_TRIG_EN
  localparam bit AUTO_ON = 1'b1;
`else
  localparam bit AUTO_ON = 1'b0;
`endif

  logic                     rclk;
  logic                     rst;
  logic                     arm;
  logic [ADDR_W-1:0]        trig_pos;
  logic                     smpl_vld;
  logic [NUM_CH*DATA_W-1:0] smpl_data;
  logic                     trig;
  logic                     rd_en;
  logic [ADDR_W-1:0]        rd_addr;
  logic [NUM_CH*DATA_W-1:0] rd_data;
  logic                     rd_vld;
  logic                     busy;
  logic                     capture_done;
  logic [ADDR_W-1:0]        trig_addr;
  logic                     auto_trig;

  capture_ram_ctrl #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .NUM_CH (NUM_CH),
    .AUTO_TO(AUTO_TO)
  ) dut (
    .rclk        (rclk),
    .rst         (rst),
    .arm         (arm),
    .trig_pos    (trig_pos),
    .smpl_vld    (smpl_vld),
    .smpl_data   (smpl_data),
    .trig        (trig),
    .rd_en       (rd_en),
    .rd_addr     (rd_addr),
    .rd_data     (rd_data),
    .rd_vld      (rd_vld),
    .busy        (busy),
    .capture_done(capture_done),
    .trig_addr   (trig_addr),
    .auto_trig   (auto_trig)
  );

  initial rclk = 1'b0;
  always #5 rclk = ~rclk;

  int passCount = 0;
  int totalCount = 0;

  // Reference model state.
  bit   mArmed   = 1'b0;
  int   mTp      = 0;
  int   mN       = 0;
  int   mTrigIdx = -1;
  int   hist[$];
  int   eRdData    = 0;
  int   eRdVld     = 0;
  int   eTrigAddr  = 0;
  int   eAuto      = 0;

  task automatic checkOutput(input string tag, input int got, input int exp);
    totalCount++;
    if (got == exp) begin
      passCount++;
    end else begin
      $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // The capture is complete once DEPTH-tp samples have been written from
  // the trigger sample onward.
  function automatic bit mDone();
    return mArmed && (mTrigIdx >= 0) && (mN == mTrigIdx + DEPTH - mTp);
  endfunction

  function automatic bit mBusy();
    return mArmed && !mDone();
  endfunction

  task automatic modelStep(input bit r, input bit a, input int tp, input bit v,
                           input int d, input bit t, input bit re, input int ra);
    bit dn;
    bit bz;
    bit to;
    dn = mDone();
    bz = mBusy();
    if (r) begin
      mArmed = 1'b0; mTp = 0; mN = 0; mTrigIdx = -1; hist.delete();
      eRdData = 0; eRdVld = 0; eTrigAddr = 0; eAuto = 0;
    end else if (a) begin
      mArmed = 1'b1; mTp = tp; mN = 0; mTrigIdx = -1; hist.delete();
      eAuto = 0; eRdVld = 0;
    end else begin
      eRdVld = 0;
      if (dn && re) begin
        eRdVld  = 1;
        eRdData = hist[mN - DEPTH + ra];
      end
      if (bz && v) begin
        // Samples past the first tp ones are taken while waiting for a trigger.
        if (mTrigIdx < 0 && mN >= mTp) begin
          to = AUTO_ON && ((mN - mTp) == AUTO_TO - 1);
          if (t || to) begin
            mTrigIdx  = mN;
            eTrigAddr = mN % DEPTH;
            eAuto     = t ? 0 : 1;
          end
        end
        hist.push_back(d % 256);
        mN++;
      end
    end
  endtask

  task automatic checkAll();
    checkOutput("rd_vld",       int'(rd_vld),       eRdVld);
    checkOutput("rd_data",      int'(rd_data),      eRdData);
    checkOutput("busy",         int'(busy),         int'(mBusy()));
    checkOutput("capture_done", int'(capture_done), int'(mDone()));
    checkOutput("trig_addr",    int'(trig_addr),    eTrigAddr);
    checkOutput("auto_trig",    int'(auto_trig),    eAuto);
  endtask

  // Drive one cycle of inputs (called just after a falling edge), let the
  // DUT and the model take the rising edge, then check on the falling edge.
  task automatic applyStimulus(input bit r, input bit a, input int tp, input bit v,
                               input int d, input bit t, input bit re, input int ra);
    rst       = r;
    arm       = a;
    trig_pos  = ADDR_W'(tp);
    smpl_vld  = v;
    smpl_data = 8'(d);
    trig      = t;
    rd_en     = re;
    rd_addr   = ADDR_W'(ra);
    @(posedge rclk);
    modelStep(r, a, tp, v, d, t, re, ra);
    @(negedge rclk);
    checkAll();
  endtask

  // Arm and feed samples until the model says the capture is complete, or
  // until maxCycles have gone by.
  //   trigSample: valid-sample index that carries trig
  //               (-1 = random trigger, -2 = never)
  //   vldMode:    0 = every cycle, 1 = alternating (trig on every invalid
  //               cycle), 2 = random
  //   preTrig:    extra valid-sample index that carries trig
  //   armRd:      assert rd_en in the arm cycle
  task automatic runCapture(input int tp, input int trigSample, input int vldMode,
                            input bit ramp, input int preTrig, input bit armRd,
                            input int maxCycles, input bit mustFinish);
    int s;
    int cyc;
    bit v;
    bit t;
    int d;
    applyStimulus(0, 1, tp, 0, 0, 0, armRd, 3);
    s = 0;
    cyc = 0;
    while (!mDone() && cyc < maxCycles) begin
      case (vldMode)
        0:       v = 1'b1;
        1:       v = (cyc % 2 == 0);
        default: v = ($urandom_range(0, 3) != 0);
      endcase
      d = ramp ? s : int'($urandom_range(0, 255));
      if (v) begin
        if (trigSample == -1) t = ($urandom_range(0, 63) == 0);
        else                  t = (s == trigSample) || (s == preTrig);
      end else begin
        t = (vldMode == 1) ? 1'b1 : ($urandom_range(0, 3) == 0);
      end
      applyStimulus(0, 0, tp, v, d, t, 1'($urandom_range(0, 1)),
                    int'($urandom_range(0, DEPTH-1)));
      if (v) s++;
      cyc++;
    end
    if (mustFinish) checkOutput("capture_finished", int'(capture_done), 1);
  endtask

  // Read out the buffer: either every logical index back-to-back, or random
  // indices with gaps while samples and triggers keep arriving.
  task automatic readAll(input bit randomOrder);
    if (!randomOrder) begin
      for (int k = 0; k < DEPTH; k++) begin
        applyStimulus(0, 0, 0, 0, 0, 0, 1, k);
      end
    end else begin
      for (int k = 0; k < 96; k++) begin
        applyStimulus(0, 0, 0, 1'($urandom_range(0, 1)), int'($urandom_range(0, 255)),
                      1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0),
                      int'($urandom_range(0, DEPTH-1)));
      end
    end
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    rst = 1'b1; arm = 1'b0; trig_pos = '0; smpl_vld = 1'b0; smpl_data = '0;
    trig = 1'b0; rd_en = 1'b0; rd_addr = '0;
    @(negedge rclk);

    $display("[TB] reset and idle read");
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 0, 0, 1, 5);
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 5);
    applyStimulus(0, 0, 0, 1, 7, 1, 1, 5);

    $display("[TB] trig_pos=100, ramp, trigger at sample 300");
    runCapture(100, 300, 0, 1, -1, 0, 2000, 1);
    checkOutput("trig_addr_300", int'(trig_addr), 300);
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 0);
    checkOutput("oldest_sample_200", int'(rd_data), 200);
    readAll(0);

    $display("[TB] trig_pos=0, trigger on first sample");
    runCapture(0, 0, 0, 1, -1, 0, 2000, 1);
    checkOutput("trig_addr_zero", int'(trig_addr), 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 0);
    checkOutput("index0_is_trigger", int'(rd_data), 0);
    readAll(1);

    $display("[TB] trigger during PRE ignored");
    runCapture(50, 60, 0, 1, 10, 0, 2000, 1);
    checkOutput("trig_addr_60", int'(trig_addr), 60);
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 50);
    checkOutput("index50_is_60", int'(rd_data), 60);
    readAll(0);

    $display("[TB] alternating smpl_vld, trig on invalid cycles");
    runCapture(20, 40, 1, 1, -1, 0, 3000, 1);
    readAll(1);

    $display("[TB] arm during POST");
    runCapture(30, 35, 0, 1, -1, 0, 100, 0);
    runCapture(10, -1, 2, 0, -1, 0, 6000, 1);
    readAll(1);

    $display("[TB] arm concurrent with rd_en in DONE");
    runCapture(5, -1, 2, 0, -1, 1, 6000, 1);
    readAll(1);

    $display("[TB] trig_pos=511 boundary");
    runCapture(511, 600, 0, 1, -1, 0, 3000, 1);
    readAll(0);

    $display("[TB] reset mid-capture");
    runCapture(64, -2, 2, 0, -1, 0, 100, 0);
    applyStimulus(1, 0, 0, 1, 3, 1, 1, 0);
    applyStimulus(0, 0, 0, 1, 3, 1, 1, 0);

    $display("[TB] random captures");
    for (int i = 0; i < 3; i++) begin
      runCapture(int'($urandom_range(0, DEPTH-1)), -1, 2, 0, -1, 0, 8000, 1);
      readAll(1);
    end

`ifdef CAPTURE_AUTO_TRIG_EN
    $display("[TB] auto trigger timeout");
    runCapture(100, -2, 0, 1, -1, 0, 3000, 1);
    checkOutput("auto_trig_set", int'(auto_trig), 1);
    checkOutput("auto_trig_addr", int'(trig_addr), (100 + AUTO_TO - 1) % DEPTH);
    readAll(0);
    runCapture(20, 30, 0, 1, -1, 0, 3000, 1);
    checkOutput("auto_trig_cleared", int'(auto_trig), 0);
`endif

    $display("%0d/%0d checks passed", passCount, totalCount);
    $finish;
  end

endmodule
